cim_controller: RTL and testbench



---
 rtl/cim_ctrl_pkg.sv | 42 ++++
 rtl/cim_controller_simd_lane_pipe.sv | 71 +++++++
 rtl/cim_controller.sv | 126 ++++++++++++
 tb/tb_cim_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_ctrl_pkg.sv
// cim_ctrl_pkg
// Shared definitions for the CIM post-processing controller: bus widths,
// configuration register indices, opcode (reg7) field positions and the
// controller FSM state encoding.
package cim_ctrl_pkg;

  localparam int DATA_OUT_WIDTH = 32;
  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_DEPTH      = 16;
  localparam int REG_ADDR       = 4;
  localparam int Q_WIDTH        = 64;
  localparam int LANE_W         = 4;
  localparam int N_LANES        = Q_WIDTH / LANE_W;

  // Configuration register indices
  localparam int REG_CTRL   = 0;
  localparam int REG_WDATA  = 1;
  localparam int REG_OPA_LO = 5;
  localparam int REG_OPA_HI = 6;
  localparam int REG_OP     = 7;

  // reg0 bits
  localparam int CTRL_RUN_BIT = 0;
  localparam int CTRL_COL_BIT = 1;

  // reg7 (opcode) fields
  localparam int OP_SHAMT_LSB = 0;
  localparam int OP_SHDIR_BIT = 3;
  localparam int OP_SUB_BIT   = 6;
  localparam int OP_ALU_BIT   = 7;
  localparam int OP_ROT_LSB   = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POP  = 3'd1,
    ST_CAL  = 3'd2,
    ST_PROC = 3'd3,
    ST_WR0  = 3'd4,
    ST_WR1  = 3'd5
  } state_t;

endpackage

// File: rtl/cim_controller_simd_lane_pipe.sv
// simd_lane_pipe
// Combinational lane-wise post-processing of a 64-bit CIM result:
// per-lane shift -> optional per-lane add/subtract -> whole-word lane rotate.
// Optional feature macro: CIM_CTRL_SIMD_ALU_EN (add/subtract stage present
// when defined; otherwise the shift output feeds the rotate stage directly).
// Ports:
//   qin      : 64-bit input word (16 lanes x 4 bits)
//   shamt    : per-lane shift amount, values >= 4 clear the lane
//   sh_right : 1 = logical right shift, 0 = left shift
//   alu_en   : enable add/subtract stage
//   alu_sub  : 1 = subtract operand, 0 = add operand
//   opa_lo   : operand nibbles for lanes 0-7
//   opa_hi   : operand nibbles for lanes 8-15
//   rot      : rotate right by 4*rot bits
//   result   : processed 64-bit word
module simd_lane_pipe
  import cim_ctrl_pkg::*;
(
  input  logic [Q_WIDTH-1:0]        qin,
  input  logic [2:0]                shamt,
  input  logic                      sh_right,
  input  logic                      alu_en,
  input  logic                      alu_sub,
  input  logic [REG_DATA_WIDTH-1:0] opa_lo,
  input  logic [REG_DATA_WIDTH-1:0] opa_hi,
  input  logic [3:0]                rot,
  output logic [Q_WIDTH-1:0]        result
);

  logic [Q_WIDTH-1:0] opa;
  logic [Q_WIDTH-1:0] lanes;
  logic [LANE_W-1:0]  lane;
  logic [3:0]         src;

  assign opa = {opa_hi, opa_lo};

  always_comb begin
    lanes  = '0;
    lane   = '0;
    src    = '0;
    result = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane = qin[i*LANE_W +: LANE_W];
      // Amounts 4..7 push every bit out of a 4-bit lane.
      if (shamt[2])
        lane = '0;
      else if (sh_right)
        lane = lane >> shamt[1:0];
      else
        lane = lane << shamt[1:0];
`ifdef CIM_CTRL_SIMD_ALU_EN
      // 4-bit arithmetic wraps per lane, no carry into the neighbour.
      if (alu_en)
        lane = alu_sub ? (lane - opa[i*LANE_W +: LANE_W])
                       : (lane + opa[i*LANE_W +: LANE_W]);
`endif
      lanes[i*LANE_W +: LANE_W] = lane;
    end
    // Rotate right by whole lanes: output lane i takes input lane (i+rot) mod 16.
    for (int i = 0; i < N_LANES; i++) begin
      src = 4'(i) + rot;
      result[i*LANE_W +: LANE_W] = lanes[src*LANE_W +: LANE_W];
    end
  end

`ifndef CIM_CTRL_SIMD_ALU_EN
  logic unused_alu;
  assign unused_alu = ^{alu_en, alu_sub, opa};
`endif

endmodule

// File: rtl/cim_controller.sv
// cim_controller
// CIM post-processing controller: pops one input vector, requests a CIM
// calculation, post-processes the 64-bit result through simd_lane_pipe and
// pushes it to the output FIFO as two 32-bit words (low word first).
// Also holds the 16 x 32-bit host configuration register file.
// Optional feature macro: CIM_CTRL_SIMD_ALU_EN (see simd_lane_pipe).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   reg_en/a_reg/d_reg: host register write strobe/address/data
//   empty_inputfifo   : input FIFO empty;  RD_EN_inputfifo : pop pulse
//   cal_b / cal_done  : calculation request / completion
//   qin               : CIM result
//   full_outputfifo   : output FIFO full;  WR_EN_outputfifo/qout : push/data
//   col_en            : reg0[1];  data_cim_in : reg1
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | wait for RUN and a non-empty input FIFO
// POP   | one-cycle input FIFO pop
// CAL   | hold cal_b until cal_done is sampled high
// PROC  | register the processed result (reg5/6/7 sampled here)
// WR0   | push result[31:0], stall while output FIFO is full
// WR1   | push result[63:32], stall while output FIFO is full
module cim_controller
  import cim_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reg_en,
  input  logic [REG_ADDR-1:0]       a_reg,
  input  logic [REG_DATA_WIDTH-1:0] d_reg,
  input  logic                      empty_inputfifo,
  output logic                      RD_EN_inputfifo,
  output logic                      cal_b,
  input  logic                      cal_done,
  input  logic [Q_WIDTH-1:0]        qin,
  input  logic                      full_outputfifo,
  output logic                      WR_EN_outputfifo,
  output logic [DATA_OUT_WIDTH-1:0] qout,
  output logic                      col_en,
  output logic [31:0]               data_cim_in
);

  state_t state, state_nxt;

  logic [REG_DATA_WIDTH-1:0] regs [REG_DEPTH];
  logic [Q_WIDTH-1:0]        result_q;
  logic [Q_WIDTH-1:0]        pipe_result;
  logic                      run;

  assign run         = regs[REG_CTRL][CTRL_RUN_BIT];
  assign col_en      = regs[REG_CTRL][CTRL_COL_BIT];
  assign data_cim_in = regs[REG_WDATA];

  simd_lane_pipe u_pipe (
    .qin      (qin),
    .shamt    (regs[REG_OP][OP_SHAMT_LSB +: 3]),
    .sh_right (regs[REG_OP][OP_SHDIR_BIT]),
    .alu_en   (regs[REG_OP][OP_ALU_BIT]),
    .alu_sub  (regs[REG_OP][OP_SUB_BIT]),
    .opa_lo   (regs[REG_OPA_LO]),
    .opa_hi   (regs[REG_OPA_HI]),
    .rot      (regs[REG_OP][OP_ROT_LSB +: 4]),
    .result   (pipe_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      result_q <= '0;
      for (int i = 0; i < REG_DEPTH; i++)
        regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (reg_en)
        regs[a_reg] <= d_reg;
      if (state == ST_PROC)
        result_q <= pipe_result;
    end
  end

  always_comb begin
    state_nxt        = state;
    RD_EN_inputfifo  = 1'b0;
    cal_b            = 1'b0;
    WR_EN_outputfifo = 1'b0;
    qout             = '0;
    case (state)
      ST_IDLE: if (run && !empty_inputfifo) state_nxt = ST_POP;
      ST_POP: begin
        RD_EN_inputfifo = 1'b1;
        state_nxt       = ST_CAL;
      end
      ST_CAL: begin
        cal_b = 1'b1;
        if (cal_done) state_nxt = ST_PROC;
      end
      ST_PROC: state_nxt = ST_WR0;
      ST_WR0: begin
        qout = result_q[31:0];
        if (!full_outputfifo) begin
          WR_EN_outputfifo = 1'b1;
          state_nxt        = ST_WR1;
        end
      end
      ST_WR1: begin
        qout = result_q[63:32];
        if (!full_outputfifo) begin
          WR_EN_outputfifo = 1'b1;
          state_nxt        = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A reset cycle must never pop, push or request a calculation.
    if (rst) begin
      RD_EN_inputfifo  = 1'b0;
      cal_b            = 1'b0;
      WR_EN_outputfifo = 1'b0;
    end
  end

  logic unused_regs;
  assign unused_regs = ^{regs[REG_CTRL][31:2], regs[REG_OP][31:12], regs[REG_OP][5:4]};

endmodule

// File: tb/tb_cim_controller.sv
module tb_cim_controller;

`ifdef CIM_CTRL_SIMD_ALU_EN
  localparam bit ALU_ON = 1'b1;
`else
  localparam bit ALU_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_en = 1'b0;
  logic [3:0]  a_reg = '0;
  logic [31:0] d_reg = '0;
  logic        empty_inputfifo = 1'b1;
  logic        RD_EN_inputfifo;
  logic        cal_b;
  logic        cal_done = 1'b0;
  logic [63:0] qin = '0;
  logic        full_outputfifo = 1'b0;
  logic        WR_EN_outputfifo;
  logic [31:0] qout;
  logic        col_en;
  logic [31:0] data_cim_in;

  cim_controller dut (
    .clk              (clk),
    .rst              (rst),
    .reg_en           (reg_en),
    .a_reg            (a_reg),
    .d_reg            (d_reg),
    .empty_inputfifo  (empty_inputfifo),
    .RD_EN_inputfifo  (RD_EN_inputfifo),
    .cal_b            (cal_b),
    .cal_done         (cal_done),
    .qin              (qin),
    .full_outputfifo  (full_outputfifo),
    .WR_EN_outputfifo (WR_EN_outputfifo),
    .qout             (qout),
    .col_en           (col_en),
    .data_cim_in      (data_cim_in)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain per-lane arithmetic on nibble values.
  function automatic logic [63:0] model(input logic [63:0] q, input logic [31:0] op,
                                        input logic [31:0] lo, input logic [31:0] hi);
    int ln [16];
    int amt, n;
    logic [63:0] opa, r;
    opa = {hi, lo};
    amt = int'(op[2:0]);
    n   = int'(op[11:8]);
    for (int i = 0; i < 16; i++) begin
      ln[i] = int'(q[4*i +: 4]);
      if (amt >= 4)   ln[i] = 0;
      else if (op[3]) ln[i] = ln[i] / (1 << amt);
      else            ln[i] = (ln[i] * (1 << amt)) % 16;
`ifdef CIM_CTRL_SIMD_ALU_EN
      if (op[7]) begin
        int o;
        o = int'(opa[4*i +: 4]);
        ln[i] = op[6] ? (ln[i] - o + 16) % 16 : (ln[i] + o) % 16;
      end
`endif
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = 4'(ln[(i + n) % 16]);
    return r;
  endfunction

  // ---------------- environment drivers ----------------
  int cal_wait = 0;
  bit cal_pre  = 0;
  int cal_drv_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (cal_pre) cal_done = 1'b1;
    else if (cal_b) begin
      cal_done = (cal_drv_cnt >= cal_wait);
      cal_drv_cnt++;
    end else begin
      cal_done = 1'b0;
      cal_drv_cnt = 0;
    end
  end

  bit full_mode  = 0;
  bit full_force = 0;
  always @(posedge clk) begin
    #1;
    if (full_mode) full_outputfifo = ($urandom_range(0, 3) == 0);
    else           full_outputfifo = full_force;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] m_regs [16] = '{default: 32'h0};
  logic [31:0] expq [$];
  logic [31:0] push_log [2];
  logic [63:0] r;
  logic [31:0] w;
  bit m_idle = 1;
  bit exp_pop = 0;
  bit done_now;
  bit full_seen, full_seen2;
  int cyc = 0, pop_cyc = 0, fp_cyc = 0, cal_cnt = 0, push_n = 0;
  int pop_count = 0, done_count = 0, exp_cal_len = 1;

  always @(negedge clk) begin
    done_now = 0;
    cyc++;
    chk("col_en", col_en, m_regs[0][1]);
    chk("data_cim_in", data_cim_in, m_regs[1]);
    chk("rd_en", RD_EN_inputfifo, exp_pop);
    if (rst) begin
      chk("wr_en_in_rst", WR_EN_outputfifo, 0);
      chk("cal_b_in_rst", cal_b, 0);
    end
    if (m_idle) begin
      chk("cal_b_idle", cal_b, 0);
      chk("wr_en_idle", WR_EN_outputfifo, 0);
    end
    if (RD_EN_inputfifo) begin
      pop_count++;
      if (exp_pop) begin
        m_idle = 0; pop_cyc = cyc; cal_cnt = 0; push_n = 0;
        full_seen = 0; full_seen2 = 0;
        r = model(qin, m_regs[7], m_regs[5], m_regs[6]);
        expq.push_back(r[31:0]);
        expq.push_back(r[63:32]);
      end
    end
    if (!m_idle && cal_b) cal_cnt++;
    if (!m_idle && full_outputfifo) begin
      if (push_n == 0) full_seen = 1;
      else             full_seen2 = 1;
    end
    if (WR_EN_outputfifo) begin
      if (expq.size() == 0) chk("unexpected_push", WR_EN_outputfifo, 0);
      else begin
        w = expq.pop_front();
        chk("qout", qout, w);
        chk("push_while_full", full_outputfifo, 0);
        if (push_n == 0) begin
          if (!full_seen) chk("first_push_latency", cyc - pop_cyc, cal_cnt + 2);
          chk("cal_cycles", cal_cnt, exp_cal_len);
          fp_cyc = cyc;
        end else if (!full_seen2) chk("wr0_wr1_gap", cyc - fp_cyc, 1);
        if (push_n < 2) push_log[push_n] = qout;
        push_n++;
        if (push_n == 2) done_now = 1;
      end
    end
    if (rst) begin
      expq.delete();
      m_idle = 1; exp_pop = 0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
    end else begin
      exp_pop = m_idle && m_regs[0][0] && !empty_inputfifo;
      if (done_now) begin m_idle = 1; done_count++; end
      if (reg_en) m_regs[a_reg] = d_reg;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_en = 1'b1; a_reg = a; d_reg = d;
    @(posedge clk); #1;
    reg_en = 1'b0;
  endtask

  task automatic wait_pop(input int pc);
    int n = 0;
    while (pop_count == pc && n < 60) begin @(posedge clk); n++; end
    chk("pop_seen", pop_count - pc, 1);
  endtask

  task automatic wait_done(input int dc);
    int n = 0;
    while (done_count == dc && n < 300) begin @(posedge clk); n++; end
    chk("vector_done", done_count - dc, 1);
  endtask

  task automatic run_vector(input logic [63:0] q, input int wt, input bit pre);
    int pc, dc;
    @(posedge clk); #1;
    pc = pop_count; dc = done_count;
    qin = q; cal_wait = wt; cal_pre = pre;
    exp_cal_len = pre ? 1 : wt + 1;
    empty_inputfifo = 1'b0;
    wait_pop(pc);
    #1 empty_inputfifo = 1'b1;
    wait_done(dc);
    #1 cal_pre = 0;
  endtask

  task automatic run_dir(input string nm, input logic [31:0] op, input logic [31:0] lo,
                         input logic [31:0] hi, input logic [63:0] q,
                         input logic [31:0] e0, input logic [31:0] e1);
    wr_reg(5, lo); wr_reg(6, hi); wr_reg(7, op);
    run_vector(q, $urandom_range(0, 2), 1'b0);
    chk({nm, "_w0"}, push_log[0], e0);
    chk({nm, "_w1"}, push_log[1], e1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pc, dc;
    logic [31:0] op;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", RD_EN_inputfifo, 0);
    chk("rst_cal_b", cal_b, 0);
    chk("rst_wr_en", WR_EN_outputfifo, 0);
    chk("rst_qout", qout, 0);
    chk("rst_col_en", col_en, 0);
    chk("rst_data_cim_in", data_cim_in, 0);

    chk("pin_shr1", model(64'h7777777777777777, 32'h9, 0, 0), 64'h3333333333333333);
    chk("pin_shl3", model(64'h7777777777777777, 32'h3, 0, 0), 64'h8888888888888888);
    chk("pin_rot4", model(64'h0123456789ABCDEF, 32'h400, 0, 0), 64'hCDEF0123456789AB);
    chk("pin_sub_wrap", model(64'h7777777777777777, 32'hC0, 32'h88888888, 32'h88888888),
        ALU_ON ? 64'hFFFFFFFFFFFFFFFF : 64'h7777777777777777);

    wr_reg(0, 32'h3);
    wr_reg(1, 32'hA5A5_1234);
    run_dir("shr1", 32'h9, 0, 0, 64'h7777777777777777, 32'h33333333, 32'h33333333);
    run_dir("shl3", 32'h3, 0, 0, 64'h7777777777777777, 32'h88888888, 32'h88888888);
    run_dir("shl7", 32'h7, 0, 0, 64'h7777777777777777, 32'h0, 32'h0);
    run_dir("sub1", 32'hC0, 32'h11111111, 32'h11111111, 64'h7777777777777777,
            ALU_ON ? 32'h66666666 : 32'h77777777, ALU_ON ? 32'h66666666 : 32'h77777777);
    run_dir("sub8", 32'hC0, 32'h88888888, 32'h88888888, 64'h7777777777777777,
            ALU_ON ? 32'hFFFFFFFF : 32'h77777777, ALU_ON ? 32'hFFFFFFFF : 32'h77777777);
    run_dir("add_wrap", 32'h80, 32'h11111111, 32'h11111111, 64'hFFFFFFFFFFFFFFFF,
            ALU_ON ? 32'h0 : 32'hFFFFFFFF, ALU_ON ? 32'h0 : 32'hFFFFFFFF);
    run_dir("pass", 32'h0, 32'h12345678, 32'h9ABCDEF0, 64'h0123456789ABCDEF,
            32'h89ABCDEF, 32'h01234567);

    // cal_done already high when CAL is entered
    run_vector(64'h0123456789ABCDEF, 0, 1'b1);

    // output FIFO full while in WR0
    wr_reg(7, 32'h400);
    @(posedge clk); #1 full_force = 1'b1;
    @(posedge clk); #1;
    pc = pop_count; dc = done_count;
    qin = 64'h0123456789ABCDEF; cal_wait = 0; exp_cal_len = 1;
    empty_inputfifo = 1'b0;
    wait_pop(pc);
    #1 empty_inputfifo = 1'b1;
    repeat (6) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("full_no_push", WR_EN_outputfifo, 0);
      chk("full_qout_stable", qout, 32'h456789AB);
    end
    @(posedge clk); #1 full_force = 1'b0;
    wait_done(dc);
    chk("rot_w0", push_log[0], 32'h456789AB);
    chk("rot_w1", push_log[1], 32'hCDEF0123);

    // RUN=0 with a non-empty FIFO: no pop
    wr_reg(0, 32'h0);
    @(posedge clk); #1;
    pc = pop_count;
    empty_inputfifo = 1'b0;
    repeat (10) @(posedge clk);
    chk("run0_no_pop", pop_count - pc, 0);
    #1 empty_inputfifo = 1'b1;

    // RUN cleared mid-operation: current vector finishes, no next pop
    wr_reg(0, 32'h1);
    wr_reg(7, 32'h9);
    @(posedge clk); #1;
    pc = pop_count; dc = done_count;
    qin = 64'hFEDCBA9876543210; cal_wait = 3; exp_cal_len = 4;
    empty_inputfifo = 1'b0;
    wait_pop(pc);
    wr_reg(0, 32'h0);
    wait_done(dc);
    repeat (8) @(posedge clk);
    chk("run_clear_single_pop", pop_count - pc, 1);
    #1 empty_inputfifo = 1'b1;

    // reset during CAL
    wr_reg(0, 32'h3);
    @(posedge clk); #1;
    pc = pop_count; dc = done_count;
    qin = 64'h7777777777777777; cal_wait = 20; exp_cal_len = 21;
    empty_inputfifo = 1'b0;
    wait_pop(pc);
    #1 empty_inputfifo = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstcal_rd_en", RD_EN_inputfifo, 0);
    chk("rstcal_cal_b", cal_b, 0);
    chk("rstcal_wr_en", WR_EN_outputfifo, 0);
    chk("rstcal_qout", qout, 0);
    chk("rstcal_col_en", col_en, 0);
    chk("rstcal_data_cim_in", data_cim_in, 0);
    repeat (15) @(posedge clk);
    chk("rstcal_no_done", done_count - dc, 0);
    wr_reg(0, 32'h1);
    run_dir("after_rst", 32'h9, 0, 0, 64'h7777777777777777, 32'h33333333, 32'h33333333);

    // randomized vectors with random back-pressure
    full_mode = 1;
    for (int v = 0; v < 30; v++) begin
      wr_reg(0, $urandom | 32'h1);
      wr_reg(1, $urandom);
      wr_reg(5, $urandom);
      wr_reg(6, $urandom);
      op = $urandom;
      if ($urandom_range(0, 1) == 1) op = op & 32'hFFF;
      wr_reg(7, op);
      run_vector({$urandom, $urandom}, $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    end
    full_mode = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
